hacd_axi_line_master: RTL
=========================

// Module: hacd_axi_line_master
// PURPOSE
//  Converts single 64-byte cacheline read/write requests from the HACD/Hawk engine into AXI4 bursts
//  (2 beats x 256 bit, INCR) on the memory-controller AXI port. Sits directly upstream of the MC AXI
//  slave (DRAM or behavioural memory). Returns one response per request. One request in flight at a time.
// PARAMETERS
//  AXI_ID      6'd0   default AXI ID driven on AW/AR when req_id is not used (USE_REQ_ID=0)
//  USE_REQ_ID  1      1: axi_awid/axi_arid = req_id; 0: = AXI_ID
// PORTS
//  clk            in   1    clock, all logic on rising edge
//  rst            in   1    synchronous reset, active high
//  req_valid      in   1    line request valid
//  req_ready      out  1    request accepted when req_valid & req_ready
//  req_wr         in   1    1 = write, 0 = read
//  req_addr       in   64   byte address, bits [5:0] must be 0
//  req_id         in   6    transaction tag, echoed on response
//  req_wdata      in   512  write line; [255:0] = beat 0, [511:256] = beat 1
//  req_wstrb      in   64   byte enables; [31:0] beat 0, [63:32] beat 1
//  rsp_valid      out  1    response valid, held until rsp_ready
//  rsp_ready      in   1    response consumer ready
//  rsp_wr         out  1    1 = write completion, 0 = read data
//  rsp_id         out  6    req_id of the completed request
//  rsp_rdata      out  512  read line (0 for writes)
//  rsp_err        out  1    non-OKAY resp, ID mismatch or rlast error
//  axi_aw{valid,ready,id[5:0],addr[63:0],len[7:0],size[2:0],burst[1:0]}  out/in  AXI4 write address
//  axi_w{valid,ready,data[255:0],strb[31:0],last}                        out/in  AXI4 write data
//  axi_b{valid,ready,id[5:0],resp[1:0]}                                  in/out  AXI4 write response
//  axi_ar{valid,ready,id[5:0],addr[63:0],len[7:0],size[2:0],burst[1:0]}  out/in  AXI4 read address
//  axi_r{valid,ready,id[5:0],data[255:0],resp[1:0],last}                 in/out  AXI4 read data
//  wr_done_cnt    out  32   completed writes, wraps at 2^32
//  rd_done_cnt    out  32   completed reads, wraps at 2^32
// BEHAVIOUR
//  Reset: FSM=IDLE; all AXI valid/ready outputs, req_ready, rsp_valid, rsp_err = 0; rsp_rdata = 0; counters = 0.
//  Constants: axlen=8'd1, axsize=3'd5, axburst=2'b01; axaddr = {req_addr[63:6],6'b0} (bits [5:0] forced 0).
//  FSM: IDLE -> (accept, wr) AW -> W0 -> W1 -> B -> RSP -> IDLE;  IDLE -> (accept, rd) AR -> R0 -> R1 -> RSP -> IDLE.
//  IDLE: req_ready=1; on handshake capture wr/addr/id/wdata/wstrb into regs; next cycle drive AW or AR.
//  AW/AR: axvalid=1 held, payload stable, until axready sampled high; then deassert next cycle.
//  W0: wvalid=1, wdata=line[255:0], wstrb=strb[31:0], wlast=0 until wready. W1: upper half, wlast=1.
//   W beat 0 never presented before AW handshake completes.
//  B: bready=1; on bvalid: err |= (bresp!=0) | (bid!=issued id); go RSP.
//  R0/R1: rready=1; each rvalid beat stored to low then high half; err |= rresp!=0, rid mismatch,
//   rlast on R0, or !rlast on R1. Beats with rvalid=0 ignored; no timeout.
//  RSP: rsp_valid=1 with rsp_wr/id/rdata/err stable until rsp_ready; on handshake increment wr_done_cnt or
//   rd_done_cnt, clear err, go IDLE. req_ready=0 everywhere except IDLE (no back-to-back accept in RSP).
//  Minimum latency with always-ready slave: write = accept + 5 cycles to rsp_valid; read = accept + AR + 2 beats.
//  Unexpected bvalid/rvalid outside B/R states: not consumed (ready low), no state change.
//  rst asserted mid-transaction: immediate return to IDLE, all outputs to reset values, in-flight request
//   dropped without response; environment must reset the AXI slave simultaneously.
//  Misaligned req_addr ([5:0]!=0): low bits dropped, no error flagged.
// TESTING
//  1 Write 0x1000, wdata=512'h{32{16'hA5A5}}, wstrb=all 1, slave always ready -> AW addr 0x1000 len 1 size 5,
//    2 W beats, wlast on 2nd only; rsp_valid rsp_wr=1 err=0; wr_done_cnt=1.
//  2 Read back 0x1000 -> AR addr 0x1000 len 1; rsp_rdata equals written line; rd_done_cnt=1.
//  3 Partial write 0x2000 strb=64'h0000_0000_FFFF_0000 over prior 0xFF.. line, then read -> only bytes 16..31
//    updated.
//  4 Backpressure: awready low 3 cycles, wready toggling, rsp_ready low 4 cycles -> payload stable, valids held,
//    single response, no extra beats.
//  5 Errors: bresp=2'b10 -> rsp_err=1; read with rid=id+1 -> rsp_err=1; missing rlast on beat 1 -> rsp_err=1.
//  6 rst high during W1 -> next cycle all valids 0, FSM IDLE, no rsp; fresh read afterward completes err=0.

Source files
------------

// File: rtl/hacd_axi_line_master.sv
// hacd_axi_line_master: turns one 64-byte cacheline read/write request into a
// 2-beat x 256-bit INCR AXI4 burst and returns a single response per request.
// Only one request is in flight; the FSM walks AW->W0->W1->B or AR->R0->R1,
// then holds the response until the consumer takes it.
module hacd_axi_line_master #(
   parameter logic [5:0] AXI_ID     = 6'd0,
   parameter bit         USE_REQ_ID = 1'b1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   // line request
   input  logic         i_req_valid,
   output logic         o_req_ready,
   input  logic         i_req_wr,
   input  logic [63:0]  i_req_addr,
   input  logic [5:0]   i_req_id,
   input  logic [511:0] i_req_wdata,
   input  logic [63:0]  i_req_wstrb,
   // line response
   output logic         o_rsp_valid,
   input  logic         i_rsp_ready,
   output logic         o_rsp_wr,
   output logic [5:0]   o_rsp_id,
   output logic [511:0] o_rsp_rdata,
   output logic         o_rsp_err,
   // AXI write address
   output logic         o_axi_awvalid,
   input  logic         i_axi_awready,
   output logic [5:0]   o_axi_awid,
   output logic [63:0]  o_axi_awaddr,
   output logic [7:0]   o_axi_awlen,
   output logic [2:0]   o_axi_awsize,
   output logic [1:0]   o_axi_awburst,
   // AXI write data
   output logic         o_axi_wvalid,
   input  logic         i_axi_wready,
   output logic [255:0] o_axi_wdata,
   output logic [31:0]  o_axi_wstrb,
   output logic         o_axi_wlast,
   // AXI write response
   input  logic         i_axi_bvalid,
   output logic         o_axi_bready,
   input  logic [5:0]   i_axi_bid,
   input  logic [1:0]   i_axi_bresp,
   // AXI read address
   output logic         o_axi_arvalid,
   input  logic         i_axi_arready,
   output logic [5:0]   o_axi_arid,
   output logic [63:0]  o_axi_araddr,
   output logic [7:0]   o_axi_arlen,
   output logic [2:0]   o_axi_arsize,
   output logic [1:0]   o_axi_arburst,
   // AXI read data
   input  logic         i_axi_rvalid,
   output logic         o_axi_rready,
   input  logic [5:0]   i_axi_rid,
   input  logic [255:0] i_axi_rdata,
   input  logic [1:0]   i_axi_rresp,
   input  logic         i_axi_rlast,
   // completion counters
   output logic [31:0]  o_wr_done_cnt,
   output logic [31:0]  o_rd_done_cnt
);

   typedef enum logic [3:0] {
      S_IDLE, S_AW, S_W0, S_W1, S_B, S_AR, S_R0, S_R1, S_RSP
   } state_t;

   state_t         r_state;
   logic           r_req_ready, r_awvalid, r_wvalid, r_wlast, r_bready;
   logic           r_arvalid, r_rready, r_rsp_valid, r_err, r_wr;
   logic [63:6]    r_addr;
   logic [5:0]     r_id;
   logic [511:0]   r_wdata, r_rdata;
   logic [63:0]    r_wstrb;
   logic [31:0]    r_wr_cnt, r_rd_cnt;
   logic [5:0]     w_axid;
   logic           w_unused_addr_lsb;

   // Line-aligned address only; the low six request bits are dropped silently.
   assign w_unused_addr_lsb = ^i_req_addr[5:0];
   assign w_axid            = USE_REQ_ID ? r_id : AXI_ID;

   assign o_req_ready   = r_req_ready;
   assign o_rsp_valid   = r_rsp_valid;
   assign o_rsp_wr      = r_wr;
   assign o_rsp_id      = r_id;
   assign o_rsp_rdata   = r_rdata;
   assign o_rsp_err     = r_err;

   assign o_axi_awvalid = r_awvalid;
   assign o_axi_awid    = w_axid;
   assign o_axi_awaddr  = {r_addr, 6'b0};
   assign o_axi_awlen   = 8'd1;
   assign o_axi_awsize  = 3'd5;
   assign o_axi_awburst = 2'b01;

   assign o_axi_wvalid  = r_wvalid;
   assign o_axi_wdata   = (r_state == S_W1) ? r_wdata[511:256] : r_wdata[255:0];
   assign o_axi_wstrb   = (r_state == S_W1) ? r_wstrb[63:32]   : r_wstrb[31:0];
   assign o_axi_wlast   = r_wlast;
   assign o_axi_bready  = r_bready;

   assign o_axi_arvalid = r_arvalid;
   assign o_axi_arid    = w_axid;
   assign o_axi_araddr  = {r_addr, 6'b0};
   assign o_axi_arlen   = 8'd1;
   assign o_axi_arsize  = 3'd5;
   assign o_axi_arburst = 2'b01;
   assign o_axi_rready  = r_rready;

   assign o_wr_done_cnt = r_wr_cnt;
   assign o_rd_done_cnt = r_rd_cnt;

   // Request FSM with registered handshake outputs and error accumulation.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_req_ready <= 1'b0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_wlast     <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_err       <= 1'b0;
         r_wr        <= 1'b0;
         r_addr      <= '0;
         r_id        <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_rdata     <= '0;
         r_wr_cnt    <= '0;
         r_rd_cnt    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_req_ready <= 1'b1;
               if (i_req_valid && r_req_ready) begin
                  r_req_ready <= 1'b0;
                  r_wr        <= i_req_wr;
                  r_addr      <= i_req_addr[63:6];
                  r_id        <= i_req_id;
                  r_wdata     <= i_req_wdata;
                  r_wstrb     <= i_req_wstrb;
                  r_rdata     <= '0;
                  r_err       <= 1'b0;
                  if (i_req_wr) begin
                     r_awvalid <= 1'b1;
                     r_state   <= S_AW;
                  end else begin
                     r_arvalid <= 1'b1;
                     r_state   <= S_AR;
                  end
               end
            end
            S_AW: if (i_axi_awready) begin
               r_awvalid <= 1'b0;
               r_wvalid  <= 1'b1;
               r_wlast   <= 1'b0;
               r_state   <= S_W0;
            end
            S_W0: if (i_axi_wready) begin
               r_wlast <= 1'b1;
               r_state <= S_W1;
            end
            S_W1: if (i_axi_wready) begin
               r_wvalid <= 1'b0;
               r_wlast  <= 1'b0;
               r_bready <= 1'b1;
               r_state  <= S_B;
            end
            S_B: if (i_axi_bvalid) begin
               r_bready    <= 1'b0;
               r_err       <= r_err | (i_axi_bresp != 2'b00) | (i_axi_bid != w_axid);
               r_rsp_valid <= 1'b1;
               r_state     <= S_RSP;
            end
            S_AR: if (i_axi_arready) begin
               r_arvalid <= 1'b0;
               r_rready  <= 1'b1;
               r_state   <= S_R0;
            end
            S_R0: if (i_axi_rvalid) begin
               r_rdata[255:0] <= i_axi_rdata;
               r_err   <= r_err | (i_axi_rresp != 2'b00) | (i_axi_rid != w_axid) | i_axi_rlast;
               r_state <= S_R1;
            end
            S_R1: if (i_axi_rvalid) begin
               r_rdata[511:256] <= i_axi_rdata;
               r_err       <= r_err | (i_axi_rresp != 2'b00) | (i_axi_rid != w_axid) | !i_axi_rlast;
               r_rready    <= 1'b0;
               r_rsp_valid <= 1'b1;
               r_state     <= S_RSP;
            end
            S_RSP: if (i_rsp_ready) begin
               r_rsp_valid <= 1'b0;
               r_err       <= 1'b0;
               r_req_ready <= 1'b1;
               if (r_wr) r_wr_cnt <= r_wr_cnt + 32'd1;
               else      r_rd_cnt <= r_rd_cnt + 32'd1;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
